note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Playback counterpart of duration_detector: turns queued note events into a timed note_index stream.
//  Each event is (tone, duration class, rest flag). Output is one note_index per cycle with
//  note_index_ready, i.e. exactly the stream duration_detector consumes, so loopback gives the
//  events back. Sits between the score source (UART/BRAM reader) and the synth/detector.
//  An 8-deep event FIFO absorbs bursts; notes play back-to-back with no idle cycles.
// PARAMETERS
//  CLK_HZ      100_000_000  clock frequency in Hz
//  BPM         120          tempo in quarter notes per minute
//  FIFO_DEPTH  8            event FIFO entries; must be a power of 2, at least 2
//  GAP_CYCLES  4            silent articulation tail per sounded note; must be < EIGHTH
//  Derived: EIGHTH = CLK_HZ*30/BPM cycles (integer divide).
// PORTS
//  clk_in            in   1  system clock
//  rst_in            in   1  asynchronous, active-high reset
//  note_valid        in   1  event present on note_tone/note_dur/note_is_rest
//  note_ready        out  1  FIFO can accept; transfer when note_valid && note_ready
//  note_tone         in   6  tone index; 0 = silence
//  note_dur          in   2  00 eighth, 01 quarter, 10 half, 11 whole
//  note_is_rest      in   1  1 = rest, tone ignored
//  flush_in          in   1  sync pulse: drop FIFO and the current note
//  note_index        out  6  tone being played this cycle; 0 during rest/gap/idle
//  note_index_ready  out  1  high every cycle a note/rest/gap is being played
//  busy              out  1  playing, or FIFO not empty
//  fifo_count        out  $clog2(FIFO_DEPTH)+1  entries queued (excludes the note playing)
// BEHAVIOUR
//  Reset (async, any time, mid-note included): FIFO empty, state IDLE.
//   note_index=0, note_index_ready=0, busy=0, fifo_count=0; note_ready=1 once reset is released.
//  note_ready = (fifo_count != FIFO_DEPTH), from registered count only.
//   No bypass: a push into a full FIFO is refused even if a pop happens the same cycle.
//  Dur cycles D = EIGHTH << note_dur. Duration counter width: $clog2(8*EIGHTH+1).
//  Events with note_tone==0 are treated as rests.
//  FSM (all outputs registered):
//   IDLE: outputs 0, note_index_ready=0. If FIFO non-empty: pop head, load counter=D-1.
//    Go to REST if rest, else PLAY.
//   PLAY: note_index=tone, ready=1, for D-GAP_CYCLES cycles. Then GAP.
//   GAP: note_index=0, ready=1, for GAP_CYCLES cycles.
//   REST: note_index=0, ready=1, for D cycles.
//   Last cycle of PLAY/GAP/REST sequence (counter==0): if FIFO non-empty, pop and start next event
//    the very next cycle (zero bubble). Otherwise go to IDLE.
//  Latency: event accepted at edge k into an empty, idle sequencer -> FIFO holds it after k.
//   IDLE pops at k+1. First note_index cycle is registered at edge k+2.
//  Simultaneous push and pop: both happen, fifo_count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
//  flush_in (sync, highest priority after reset): FIFO emptied, state->IDLE, outputs 0 next edge.
//   A push in the same cycle as flush_in is discarded.
//  busy = (state!=IDLE) || (fifo_count!=0).
// TESTING (CLK_HZ=1000, BPM=120 -> EIGHTH=250; GAP_CYCLES=4, FIFO_DEPTH=8)
//  1 Reset: assert rst_in mid-clock -> all outputs 0 immediately.
//    After release: note_ready=1, fifo_count=0.
//  2 Push quarter, tone 10, into idle sequencer -> note_index=10 for 496 cycles starting 2 edges after accept.
//    Then 0 for 4 cycles, ready high 500 cycles total, then ready=0 and busy=0.
//  3 Push eighth 10 then eighth 10 -> 246x10, 4x0, 246x10, 4x0.
//    ready never drops between the notes; duration_detector in loopback reports two eighth notes, tone 10.
//  4 Push half rest -> note_index=0 with note_index_ready=1 for exactly 1000 cycles.
//  5 Push 10 whole notes back-to-back -> first popped, then 8 queued.
//    note_ready=0 once fifo_count=8, so the 10th push stalls until the first note ends.
//    Check fifo_count at every step; play order equals push order (pointer wrap exercised).
//  6 flush_in 100 cycles into a whole note with 3 queued -> next edge: note_index=0, ready=0, fifo_count=0, busy=0.
//    A fresh push then plays normally; repeat the case with rst_in instead of flush_in.

Source files
------------

// File: rtl/note_sequencer.sv
// Purpose: queues (tone, duration, rest) events and replays them as a timed note_index stream.
// Latency: event accepted at edge k reaches note_index at edge k+2 when idle; queued notes play with no gap.
// Backpressure: note_ready drops while the event FIFO is full; a push is refused even if a pop happens that cycle.
module note_sequencer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BPM        = 120,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [5:0]                    note_tone,
  input  logic [1:0]                    note_dur,
  input  logic                          note_is_rest,
  input  logic                          flush_in,
  output logic [5:0]                    note_index,
  output logic                          note_index_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // 64-bit product so realistic clock rates do not overflow before the divide
  localparam longint EIGHTH_L = (longint'(CLK_HZ) * 30) / longint'(BPM);
  localparam int     EIGHTH   = int'(EIGHTH_L);
  localparam int     CNT_W    = $clog2(8 * EIGHTH + 1);
  localparam int     PTR_W    = $clog2(FIFO_DEPTH);
  localparam int     CW       = PTR_W + 1;
  localparam logic [CNT_W-1:0] EIGHTH_C = CNT_W'(EIGHTH);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_REST} state_t;

  // FIFO entry: {rest, dur[1:0], tone[5:0]}; tone 0 is folded into the rest flag at push time
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, start;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dur_cycles;
  logic [5:0]       tone_q, tone_d;
  logic [5:0]       note_index_q;
  logic             ready_q;

  logic [8:0]       head;
  logic             head_rest;
  logic [1:0]       head_dur;
  logic [5:0]       head_tone;

  assign head       = mem_q[rd_ptr_q];
  assign head_rest  = head[8];
  assign head_dur   = head[7:6];
  assign head_tone  = head[5:0];
  assign dur_cycles = EIGHTH_C << head_dur;

  assign note_ready       = (count_q != CW'(FIFO_DEPTH));
  assign push             = note_valid && note_ready && !flush_in;
  assign fifo_count       = count_q;
  assign note_index       = note_index_q;
  assign note_index_ready = ready_q;
  assign busy             = (state_q != S_IDLE) || (count_q != '0);

  // Event storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {note_is_rest || (note_tone == 6'd0), note_dur, note_tone};
  end

  // Occupancy: push and pop in the same cycle cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_in) count_d = '0;
  end

  // FIFO pointers and count; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Playback FSM: a single down-counter spans the whole event; PLAY hands over to GAP
  // when the remaining count equals the articulation tail
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    start   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) start = 1'b1;
      end
      default: begin
        if (cnt_q == '0) begin
          if (count_q != '0) start = 1'b1;
          else               state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (state_q == S_PLAY && cnt_q == GAP_C) state_d = S_GAP;
        end
      end
    endcase
    if (start) begin
      pop     = 1'b1;
      state_d = head_rest ? S_REST : S_PLAY;
      cnt_d   = dur_cycles - CNT_W'(1);
      tone_d  = head_tone;
    end
    if (flush_in) begin
      pop     = 1'b0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tone_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
    end
  end

  // Registered output stream, one edge behind the state that produces it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      note_index_q <= '0;
      ready_q      <= 1'b0;
    end else if (flush_in) begin
      note_index_q <= '0;
      ready_q      <= 1'b0;
    end else begin
      note_index_q <= (state_q == S_PLAY) ? tone_q : 6'd0;
      ready_q      <= (state_q != S_IDLE);
    end
  end

endmodule
